// File: rtl/axi_master_port.sv
// axi_master_port: bridges the CPU single-cycle memory port onto one AXI4 master.
// Each CPU request becomes one single-beat AXI4 transaction; the pipeline is
// stalled until the response returns, then released for exactly one cycle.
// Optional feature macro: AXI_MASTER_RESP_CHECK_EN (sticky bus_err on non-OKAY
// RRESP/BRESP). Without it bus_err is tied low.
module axi_master_port #(
    parameter logic [3:0] MASTER_ID = 4'd1
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // CPU side
    input  logic        req_read,
    input  logic        req_write,
    input  logic [3:0]  req_wtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    // Read address channel
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    // Read data channel
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    // Write address channel
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    // Write data channel
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    // Write response channel
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWreq,
        StWresp,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wtype_q, wtype_d;
    logic [31:0] rdata_q, rdata_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q & AWREADY;
    assign w_hs  = wvalid_q & WREADY;

    // Single-beat IDs, last and burst info are not needed
    logic unused_inputs;
    assign unused_inputs = ^{RID, RLAST, BID};

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wtype_d   = wtype_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            StIdle: begin
                // Write takes priority when both requests are present
                if (req_write) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wtype_d   = req_wtype;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWreq;
                end else if (req_read) begin
                    addr_d    = req_addr;
                    arvalid_d = 1'b1;
                    state_d   = StRaddr;
                end
            end
            StRaddr: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = RDATA;
                    state_d  = StDone;
                end
            end
            StWreq: begin
                // AW and W complete independently; leave once both have happened
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = StWresp;
                end
            end
            StWresp: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, latched request and registered channel controls
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wtype_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wtype_q   <= wtype_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXI_MASTER_RESP_CHECK_EN
    logic bus_err_q, bus_err_d;

    // Sticky error on any non-OKAY response; cleared only by reset
    always_comb begin
        bus_err_d = bus_err_q;
        if ((state_q == StRdata) && RVALID && (RRESP != 2'b00)) bus_err_d = 1'b1;
        if ((state_q == StWresp) && BVALID && (BRESP != 2'b00)) bus_err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{RRESP, BRESP};
    assign bus_err     = 1'b0;
`endif

    // Stall rises combinationally with the request so the CPU holds it
    assign stall = ((state_q == StIdle) & (req_read | req_write)) |
                   ((state_q != StIdle) & (state_q != StDone));

    assign rdata   = rdata_q;

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;

    assign WDATA   = wdata_q;
    assign WSTRB   = ~wtype_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

endmodule
